// File: rtl/s_acc12_pkg.sv
// Shared types and constants for the s_acc12_seq saturating batch accumulator.
package s_acc12_pkg;

  localparam int unsigned ACC_W = 12;
  localparam int unsigned SUM_W = 13;

  localparam logic [ACC_W-1:0] SAT_MAX = 12'h7FF;
  localparam logic [ACC_W-1:0] SAT_MIN = 12'h800;

  typedef enum logic [0:0] {
    StAcc,
    StDone
  } state_e;

  // Returns {clamped, value}: an exact 13-bit sum folded back into 12 bits.
  function automatic logic [ACC_W:0] sat12(input logic [SUM_W-1:0] sum);
    if (sum[SUM_W-1] == sum[SUM_W-2]) begin
      sat12 = {1'b0, sum[ACC_W-1:0]};
    end else if (!sum[SUM_W-1]) begin
      sat12 = {1'b1, SAT_MAX};
    end else begin
      sat12 = {1'b1, SAT_MIN};
    end
  endfunction

endpackage

// File: rtl/s_rca12.sv
// 12-bit signed ripple-carry adder producing the exact 13-bit sign-extended sum.
module s_rca12
  import s_acc12_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [SUM_W-1:0] sum
);

  logic [SUM_W-1:0] a_ext;
  logic [SUM_W-1:0] b_ext;
  logic [SUM_W-1:0] carry;

  assign a_ext    = {a[ACC_W-1], a};
  assign b_ext    = {b[ACC_W-1], b};
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < SUM_W; i++) begin : g_bit
    assign sum[i] = a_ext[i] ^ b_ext[i] ^ carry[i];
    // Top bit only needs its sum; the carry out of the sign-extended MSB is never used.
    if (i < SUM_W - 1) begin : g_carry
      assign carry[i+1] = (a_ext[i] & b_ext[i]) | (carry[i] & (a_ext[i] ^ b_ext[i]));
    end
  end

endmodule

// File: rtl/s_acc12_seq.sv
// Saturating batch accumulator around s_rca12; emits each batch total on a valid/ready port.
module s_acc12_seq
  import s_acc12_pkg::*;
#(
  parameter int unsigned N_SAMPLES = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_count
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic [SUM_W-1:0] sum13;
  logic [ACC_W:0]   sat_res;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;

  s_rca12 u_rca (
    .a   (acc_q),
    .b   (in_data),
    .sum (sum13)
  );

  assign in_ready  = (state_q == StAcc);
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid & in_ready;
  assign sat_res   = sat12(sum13);
  assign cnt_inc   = cnt_q + CNT_W'(1);

  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_count = out_count_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_count_d = out_count_q;
    unique case (state_q)
      StAcc: begin
        if (accept) begin
          acc_d = sat_res[ACC_W-1:0];
          sat_d = sat_q | sat_res[ACC_W];
          cnt_d = cnt_inc;
        end
        // A sample arriving alongside flush is folded in before the batch closes.
        if ((accept && (cnt_inc == CNT_W'(N_SAMPLES))) ||
            (flush && ((cnt_q != '0) || accept))) begin
          state_d     = StDone;
          out_data_d  = acc_d;
          out_sat_d   = sat_d;
          out_count_d = cnt_d;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StAcc;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAcc;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_count_q <= out_count_d;
    end
  end

endmodule
